// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_adder_4bit_dataflow.sv
// 4-bit ripple-carry adder slice, pure dataflow, one full adder per bit.
module ripple_adder_4bit_dataflow
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_ci,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_co
);

  logic w_c1;
  logic w_c2;
  logic w_c3;

  // Carry chain, bit 0 to bit 3
  assign w_c1 = (i_a[0] & i_b[0]) | (i_a[0] & i_ci) | (i_b[0] & i_ci);
  assign w_c2 = (i_a[1] & i_b[1]) | (i_a[1] & w_c1) | (i_b[1] & w_c1);
  assign w_c3 = (i_a[2] & i_b[2]) | (i_a[2] & w_c2) | (i_b[2] & w_c2);
  assign o_co = (i_a[3] & i_b[3]) | (i_a[3] & w_c3) | (i_b[3] & w_c3);

  // Sum bits
  assign o_s = i_a ^ i_b ^ {w_c3, w_c2, w_c1, i_ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice reused over WIDTH/4 cycles.
// Optional signed overflow output enabled by defining OVERFLOW_DETECT_EN.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = $clog2(NIBBLES);
  localparam int unsigned SH_W    = WIDTH - NIBBLE_W;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_op_a;
  logic [WIDTH-1:0]    r_op_b;
  logic                r_carry;
  logic [SH_W-1:0]     r_sum_sh;
`ifdef OVERFLOW_DETECT_EN
  logic                r_sa;
  logic                r_sb;
`endif

  logic [NIBBLE_W-1:0] w_slice_s;
  logic                w_slice_co;
  logic [WIDTH-1:0]    w_sum_next;

  // Single shared slice operating on the low nibble of the operand shifters
  ripple_adder_4bit_dataflow u_slice (
    .i_a  (r_op_a[NIBBLE_W-1:0]),
    .i_b  (r_op_b[NIBBLE_W-1:0]),
    .i_ci (r_carry),
    .o_s  (w_slice_s),
    .o_co (w_slice_co)
  );

  // Partial sum with this cycle's nibble inserted at the top
  assign w_sum_next = {w_slice_s, r_sum_sh};

  // Sequencer FSM, datapath shifters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_carry   <= 1'b0;
      r_sum_sh  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= carry_in;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
`ifdef OVERFLOW_DETECT_EN
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          r_op_a   <= {NIBBLE_W'(0), r_op_a[WIDTH-1:NIBBLE_W]};
          r_op_b   <= {NIBBLE_W'(0), r_op_b[WIDTH-1:NIBBLE_W]};
          r_sum_sh <= w_sum_next[WIDTH-1:NIBBLE_W];
          r_carry  <= w_slice_co;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NIBBLES - 1)) begin
            sum       <= w_sum_next;
            carry_out <= w_slice_co;
            done      <= 1'b1;
            r_state   <= ST_DONE;
`ifdef OVERFLOW_DETECT_EN
            overflow  <= (r_sa == r_sb) && (w_slice_s[NIBBLE_W-1] != r_sa);
`endif
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16); covers OVERFLOW_DETECT_EN when defined.
module tb_nibble_serial_adder_ctrl;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
`ifdef OVERFLOW_DETECT_EN
  logic        overflow;
`endif

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];
  logic [15:0] last_sum;
  logic        last_co;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef OVERFLOW_DETECT_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carry_out", 32'(carry_out), 32'(e.co));
`ifdef OVERFLOW_DETECT_EN
        chk("overflow", 32'(overflow), 32'(e.ov));
`endif
      end
    end
  end

  // Issue one operation from an IDLE cycle; optionally pulse a bogus start mid-RUN
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                        input logic [15:0] es, input logic eco, input logic eov,
                        input bit inject);
    int lat;
    lat = 0;
    sb_q.push_back('{s: es, co: eco, ov: eov});
    a = ta; b = tb_v; carry_in = tci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; carry_in = ~tci;
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      if (inject && i == 1) begin a = 16'hAAAA; start = 1'b1; end
      if (inject && i == 2) start = 1'b0;
      if (i == 2) begin
        chk("sum_held_mid_run", 32'(sum), 32'(last_sum));
        chk("co_held_mid_run", 32'(carry_out), 32'(last_co));
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done within 8 edges expected 4");
    end else begin
      chk("latency", 32'(lat), 32'd4);
      chk("busy_in_done", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    last_sum = es;
    last_co  = eco;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h1111; carry_in = 1'b1;
    last_sum = 16'h0000; last_co = 1'b0;

    // Reset holds everything cleared even with start asserted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'h0000);
      chk("rst_co", 32'(carry_out), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed vectors (last arg to the expectation is signed overflow)
    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    run_op(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0);

    // Reset on the second RUN cycle aborts with no done pulse
    a = 16'h5555; b = 16'h3333; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'h0000);
    chk("abort_co", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_sum = 16'h0000; last_co = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done_sum", 32'(sum), 32'h0000);
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Signed overflow corners
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
